poly_vector_driver: RTL and testbench
=====================================

Name: poly_vector_driver

Overview:
- Synthesizable initiator for the poly_solver enable/ready/valid protocol.
- Holds a small buffer of test vectors (x, a, b, c, expected y) and plays them into a poly_solver instance one at a time.
- Compares each y against the expected value and reports pass count, first failure and timeouts.
- Used for on-FPGA self-test, replacing the file-driven simulation stimulus.

Parameters:
- DEPTH, 16, number of vector slots (power of two, ≥2).
- GAP, 5, idle clock cycles between end of one transaction and the next enable pulse.
- TIMEOUT, 1024, maximum cycles spent waiting for valid, or for ready, before aborting.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  write load_data into the next free slot.
- load_data  in  72  {x[71:64], a[63:48], b[47:32], c[31:16], expected[15:0]}, all signed.
- start  in  1  begin a run over slots 0..count-1.
- x  out  8  signed operand to solver.
- a, b, c  out  16 each  signed coefficients to solver.
- enable  out  1  one-cycle request pulse to solver.
- ready  in  1  solver idle / able to accept a request.
- valid  in  1  solver result valid.
- y  in  16  signed solver result.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start or reset.
- error  out  1  mismatch or timeout occurred; held with done.
- timeout  out  1  error was caused by timeout.
- full  out  1  count == DEPTH.
- pass_count  out  $clog2(DEPTH)+1  vectors verified correct in the current run.
- fail_index  out  $clog2(DEPTH)  slot of the failing vector.
- fail_y  out  16  y captured at the failing compare.

Behaviour:
- Reset (async, active-high) clears:
  - state to IDLE;
  - count, index and pass_count to 0;
  - enable, busy, done, error and timeout to 0;
  - x, a, b, c, fail_index and fail_y to 0.
  - Vector memory contents are not cleared.
- Loading:
  - load_en in IDLE or DONE with !full writes the slot at count; count increments.
  - load_en while busy or full is ignored.
  - If start and load_en occur in the same cycle, start wins and the load is dropped.
- State machine, states IDLE, GAP, ISSUE, WAIT_VALID, WAIT_READY, DONE:
  - IDLE/DONE + start:
    - count == 0: go to DONE next cycle, error = 0, pass_count = 0.
    - otherwise: clear index, pass_count, done, error and timeout; go to GAP.
  - GAP: count GAP cycles. Drive x/a/b/c from slot[index], stable from GAP entry through the end of WAIT_READY. Then go to ISSUE.
  - ISSUE: enable = 1 for exactly this one cycle; go to WAIT_VALID.
  - WAIT_VALID:
    - Waits for a rising edge of valid (valid high while the registered valid_q is low).
    - A valid already high on entry does not count.
    - On the edge cycle, compare y against expected:
      - equal: pass_count++ and go to WAIT_READY;
      - mismatch: latch fail_index = index and fail_y = y, set error, go to DONE (stop on first error).
  - WAIT_READY:
    - Waits for ready == 1 (level; it may already be high).
    - Then, if index == count-1, go to DONE; else index++ and go to GAP.
  - Timeout: a per-state counter resets on entry to WAIT_VALID and to WAIT_READY. On reaching TIMEOUT, set error and timeout, fail_index = index, fail_y = 0, go to DONE.
  - DONE: busy = 0, done = 1.
- busy is 1 in GAP, ISSUE, WAIT_VALID and WAIT_READY.
- start while busy is ignored.
- Reset mid-run aborts immediately. enable drops asynchronously, and the solver must be reset alongside.
- Compare is a full 16-bit signed equality; no tolerance.
- Minimum transaction length is GAP+1 cycles plus solver latency.

Decomposition:
- Shared package poly_pkg:
  - state encoding;
  - field offsets and widths for the 72-bit vector (X_W = 8, COEF_W = 16);
  - VEC_W = 72.
- poly_solver reuses X_W and COEF_W from this package.
- One natural sub-module: poly_vector_mem, a DEPTH×72 register file with one write port and one asynchronous read port addressed by index.

Test Plan:
- Load {x=2, a=1, b=2, c=3, exp=11} and {x=-3, a=2, b=-1, c=5, exp=26}; start with a real poly_solver attached.
  - Required: two single-cycle enable pulses, each at least GAP cycles apart.
  - Required at end: done = 1, error = 0, pass_count = 2.
- Load {2, 1, 2, 3, exp=12}; start.
  - Required: error = 1, timeout = 0, fail_index = 0, fail_y = 11, pass_count = 0.
  - Slot 1 is never issued.
- Solver model that never raises valid, TIMEOUT = 16.
  - Required: done, error and timeout all set exactly 16 cycles after entering WAIT_VALID, fail_index = 0.
- Start with count = 0.
  - Required: no enable pulse; done = 1 one cycle later, error = 0.
- Load DEPTH+1 vectors.
  - Required: full = 1 after DEPTH writes; the extra write is dropped and count stays at DEPTH.
  - Repeat with load_en asserted together with start: that load is dropped.
- Assert reset during WAIT_VALID of vector 1.
  - Required: all outputs return to reset values immediately.
  - Required: a fresh start runs from slot 0 with pass_count restarting at 0.

Source files
------------

// File: rtl/poly_pkg.sv
// Shared definitions for the poly_solver self-test path: vector layout and driver states.
package poly_pkg;

    localparam int unsigned X_W    = 8;
    localparam int unsigned COEF_W = 16;

    // Field offsets inside the 72-bit vector, packed LSB-first from the expected value.
    localparam int unsigned EXP_LSB = 0;
    localparam int unsigned C_LSB   = EXP_LSB + COEF_W;
    localparam int unsigned B_LSB   = C_LSB + COEF_W;
    localparam int unsigned A_LSB   = B_LSB + COEF_W;
    localparam int unsigned X_LSB   = A_LSB + COEF_W;
    localparam int unsigned VEC_W   = X_LSB + X_W;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_GAP        = 3'd1;
    localparam logic [2:0] S_ISSUE      = 3'd2;
    localparam logic [2:0] S_WAIT_VALID = 3'd3;
    localparam logic [2:0] S_WAIT_READY = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    typedef struct packed {
        logic signed [X_W-1:0]    x;
        logic signed [COEF_W-1:0] a;
        logic signed [COEF_W-1:0] b;
        logic signed [COEF_W-1:0] c;
        logic signed [COEF_W-1:0] expected;
    } poly_vec_t;

endpackage

// File: rtl/poly_vector_mem.sv
// Vector slot register file: one synchronous write port, one asynchronous read port.
module poly_vector_mem
    import poly_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  poly_vec_t       wr_data,
    input  logic [AW-1:0]   rd_addr,
    output poly_vec_t       rd_data_c
);

    poly_vec_t mem [DEPTH];

    // Contents deliberately survive reset so a reloaded run can reuse slots.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/poly_vector_driver.sv
// Plays stored test vectors into a poly_solver over enable/ready/valid and
// reports pass count, first failing slot and timeouts.
module poly_vector_driver
    import poly_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned GAP     = 5,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned IDX_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = IDX_W + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic [VEC_W-1:0]         load_data,
    input  logic                     start,
    output logic signed [X_W-1:0]    x,
    output logic signed [COEF_W-1:0] a,
    output logic signed [COEF_W-1:0] b,
    output logic signed [COEF_W-1:0] c,
    output logic                     enable,
    input  logic                     ready,
    input  logic                     valid,
    input  logic signed [COEF_W-1:0] y,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     timeout,
    output logic                     full,
    output logic [CNT_W-1:0]         pass_count,
    output logic [IDX_W-1:0]         fail_index,
    output logic signed [COEF_W-1:0] fail_y
);

    localparam int unsigned TMR_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;

    logic [2:0]               state, state_n;
    logic [CNT_W-1:0]         count, count_n;
    logic [IDX_W-1:0]         index, index_n;
    logic [TMR_W-1:0]         tmr, tmr_n;
    logic                     valid_q;
    logic [CNT_W-1:0]         pass_count_n;
    logic                     enable_n, busy_n, done_n, error_n, timeout_n, full_n;
    logic [IDX_W-1:0]         fail_index_n;
    logic signed [COEF_W-1:0] fail_y_n;
    logic signed [X_W-1:0]    x_n;
    logic signed [COEF_W-1:0] a_n, b_n, c_n;
    logic                     wr_en_c;
    logic [IDX_W-1:0]         rd_addr_c;
    logic                     last_c;
    poly_vec_t                vec;

    poly_vector_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clock     (clock),
        .wr_en     (wr_en_c),
        .wr_addr   (count[IDX_W-1:0]),
        .wr_data   (poly_vec_t'(load_data)),
        .rd_addr   (rd_addr_c),
        .rd_data_c (vec)
    );

    // Read address anticipates the slot the next GAP entry will latch.
    always_comb begin
        rd_addr_c = index;
        if (state == S_IDLE || state == S_DONE) begin
            rd_addr_c = '0;
        end else if (state == S_WAIT_READY) begin
            rd_addr_c = index + IDX_W'(1);
        end
    end

    assign last_c = (index == IDX_W'(count - CNT_W'(1)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            index      <= '0;
            tmr        <= '0;
            valid_q    <= 1'b0;
            pass_count <= '0;
            enable     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            timeout    <= 1'b0;
            full       <= 1'b0;
            fail_index <= '0;
            fail_y     <= '0;
            x          <= '0;
            a          <= '0;
            b          <= '0;
            c          <= '0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            index      <= index_n;
            tmr        <= tmr_n;
            valid_q    <= valid;
            pass_count <= pass_count_n;
            enable     <= enable_n;
            busy       <= busy_n;
            done       <= done_n;
            error      <= error_n;
            timeout    <= timeout_n;
            full       <= full_n;
            fail_index <= fail_index_n;
            fail_y     <= fail_y_n;
            x          <= x_n;
            a          <= a_n;
            b          <= b_n;
            c          <= c_n;
        end
    end

    always_comb begin
        state_n      = state;
        count_n      = count;
        index_n      = index;
        tmr_n        = tmr + TMR_W'(1);
        pass_count_n = pass_count;
        error_n      = error;
        timeout_n    = timeout;
        fail_index_n = fail_index;
        fail_y_n     = fail_y;
        x_n          = x;
        a_n          = a;
        b_n          = b;
        c_n          = c;
        wr_en_c      = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                // start has priority over a simultaneous load
                if (start) begin
                    pass_count_n = '0;
                    error_n      = 1'b0;
                    timeout_n    = 1'b0;
                    if (count == '0) begin
                        state_n = S_DONE;
                    end else begin
                        index_n = '0;
                        tmr_n   = '0;
                        state_n = S_GAP;
                    end
                end else if (load_en && !full) begin
                    wr_en_c = 1'b1;
                    count_n = count + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (tmr == TMR_W'(GAP - 1)) begin
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_n   = '0;
                state_n = S_WAIT_VALID;
            end
            S_WAIT_VALID: begin
                if (valid && !valid_q) begin
                    if (y == vec.expected) begin
                        pass_count_n = pass_count + CNT_W'(1);
                        tmr_n        = '0;
                        state_n      = S_WAIT_READY;
                    end else begin
                        fail_index_n = index;
                        fail_y_n     = y;
                        error_n      = 1'b1;
                        state_n      = S_DONE;
                    end
                end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
                    fail_index_n = index;
                    fail_y_n     = '0;
                    error_n      = 1'b1;
                    timeout_n    = 1'b1;
                    state_n      = S_DONE;
                end
            end
            S_WAIT_READY: begin
                if (ready) begin
                    if (last_c) begin
                        state_n = S_DONE;
                    end else begin
                        index_n = index + IDX_W'(1);
                        tmr_n   = '0;
                        state_n = S_GAP;
                    end
                end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
                    fail_index_n = index;
                    fail_y_n     = '0;
                    error_n      = 1'b1;
                    timeout_n    = 1'b1;
                    state_n      = S_DONE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Operands are latched once on GAP entry and held through WAIT_READY.
        if (state_n == S_GAP && state != S_GAP) begin
            x_n = vec.x;
            a_n = vec.a;
            b_n = vec.b;
            c_n = vec.c;
        end

        enable_n = (state_n == S_ISSUE);
        busy_n   = (state_n == S_GAP) || (state_n == S_ISSUE) ||
                   (state_n == S_WAIT_VALID) || (state_n == S_WAIT_READY);
        done_n   = (state_n == S_DONE);
        full_n   = (count_n == CNT_W'(DEPTH));
    end

endmodule

// File: tb/tb_poly_vector_driver.sv
// Bench for poly_vector_driver with a behavioural poly_solver (y = a*x^2 + b*x + c).
module tb_poly_vector_driver;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned GAP     = 5;
    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic signed [7:0]  x;
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic signed [15:0] c;
    } op_t;

    logic               clock;
    logic               reset;
    logic               load_en;
    logic [71:0]        load_data;
    logic               start;
    logic signed [7:0]  x;
    logic signed [15:0] a, b, c;
    logic               enable;
    logic               ready;
    logic               valid;
    logic signed [15:0] y;
    logic               busy, done, error, timeout, full;
    logic [4:0]         pass_count;
    logic [3:0]         fail_index;
    logic signed [15:0] fail_y;

    int  n_tests = 0;
    int  n_fail  = 0;
    op_t exp_q[$];
    bit  never_valid = 1'b0;

    poly_vector_driver #(
        .DEPTH   (DEPTH),
        .GAP     (GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load_en    (load_en),
        .load_data  (load_data),
        .start      (start),
        .x          (x),
        .a          (a),
        .b          (b),
        .c          (c),
        .enable     (enable),
        .ready      (ready),
        .valid      (valid),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .timeout    (timeout),
        .full       (full),
        .pass_count (pass_count),
        .fail_index (fail_index),
        .fail_y     (fail_y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic signed [15:0] poly(input int xv, input int av, input int bv, input int cv);
        int r;
        r = av * xv * xv + bv * xv + cv;
        return 16'(r);
    endfunction

    // Behavioural solver: accepts enable when ready, answers after a few cycles.
    logic signed [7:0]  s_x;
    logic signed [15:0] s_a, s_b, s_c;
    logic               s_busy;
    int                 s_cnt;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            ready  <= 1'b1;
            valid  <= 1'b0;
            y      <= '0;
            s_busy <= 1'b0;
            s_cnt  <= 0;
            s_x    <= '0;
            s_a    <= '0;
            s_b    <= '0;
            s_c    <= '0;
        end else begin
            valid <= 1'b0;
            if (valid) ready <= 1'b1;
            if (enable && ready && !s_busy) begin
                s_x    <= x;
                s_a    <= a;
                s_b    <= b;
                s_c    <= c;
                s_busy <= 1'b1;
                ready  <= 1'b0;
                s_cnt  <= 2;
            end else if (s_busy && !never_valid) begin
                if (s_cnt == 0) begin
                    valid  <= 1'b1;
                    y      <= poly(int'(s_x), int'(s_a), int'(s_b), int'(s_c));
                    s_busy <= 1'b0;
                end else begin
                    s_cnt <= s_cnt - 1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b1;
        load_en = 1'b0;
        start   = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Load one vector; push its operands to the scoreboard when it is expected to issue.
    task automatic load_vec(input int xv, input int av, input int bv, input int cv,
                            input int ev, input bit push);
        op_t op;
        @(negedge clock);
        load_en   = 1'b1;
        load_data = {8'(xv), 16'(av), 16'(bv), 16'(cv), 16'(ev)};
        @(negedge clock);
        load_en = 1'b0;
        if (push) begin
            op = {8'(xv), 16'(av), 16'(bv), 16'(cv)};
            exp_q.push_back(op);
        end
    endtask

    task automatic load_ok(input int xv, input int av, input int bv, input int cv, input bit push);
        load_vec(xv, av, bv, cv, int'(poly(xv, av, bv, cv)), push);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Runs until done, popping the scoreboard on every enable pulse.
    task automatic run_to_done(input int budget, output int n_en, output int min_gap,
                               output int en_cyc, output int done_cyc);
        op_t op;
        int  cyc;
        cyc = 0; n_en = 0; min_gap = 1000000; en_cyc = -1; done_cyc = -1;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (enable === 1'b1) begin
                if (en_cyc >= 0 && cyc - en_cyc < min_gap) min_gap = cyc - en_cyc;
                en_cyc = cyc;
                n_en++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_enable: pulse %0d with x=%0d a=%0d b=%0d c=%0d, none required",
                             n_en, x, a, b, c);
                end else begin
                    op = exp_q.pop_front();
                    if ({x, a, b, c} !== op) begin
                        n_fail++;
                        $display("FAIL operands: got x=%0d a=%0d b=%0d c=%0d, required x=%0d a=%0d b=%0d c=%0d",
                                 x, a, b, c, op.x, op.a, op.b, op.c);
                    end
                end
            end
        end
        done_cyc = cyc;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL run_done: done=%b after %0d cycles, required 1", done, cyc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({enable, busy, done, error, timeout, full} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 000000", {enable, busy, done, error, timeout, full});
        end
        n_tests++;
        if (pass_count !== 5'd0 || fail_index !== 4'd0 || fail_y !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_status: got pass=%0d idx=%0d fy=%0d, required 0 0 0", pass_count, fail_index, fail_y);
        end
        n_tests++;
        if ({x, a, b, c} !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_operands: got %h, required 0", {x, a, b, c});
        end
    endtask

    task automatic test_pass();
        int n_en, min_gap, en_cyc, done_cyc;
        do_reset();
        load_vec(2, 1, 2, 3, 11, 1'b1);
        load_vec(-3, 2, -1, 5, 26, 1'b1);
        pulse_start();
        run_to_done(500, n_en, min_gap, en_cyc, done_cyc);
        n_tests++;
        if (n_en != 2) begin
            n_fail++;
            $display("FAIL pass_enables: got %0d pulses, required 2", n_en);
        end
        n_tests++;
        if (min_gap < int'(GAP) + 1) begin
            n_fail++;
            $display("FAIL pass_spacing: got %0d cycles between pulses, required >= %0d", min_gap, GAP + 1);
        end
        n_tests++;
        if (done !== 1'b1 || error !== 1'b0 || pass_count !== 5'd2) begin
            n_fail++;
            $display("FAIL pass_status: got done=%b error=%b pass=%0d, required 1 0 2", done, error, pass_count);
        end
    endtask

    task automatic test_mismatch();
        int n_en, min_gap, en_cyc, done_cyc;
        do_reset();
        load_vec(2, 1, 2, 3, 12, 1'b1);
        load_vec(-3, 2, -1, 5, 26, 1'b0);
        pulse_start();
        run_to_done(500, n_en, min_gap, en_cyc, done_cyc);
        n_tests++;
        if (error !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL mismatch_flags: got error=%b timeout=%b, required 1 0", error, timeout);
        end
        n_tests++;
        if (fail_index !== 4'd0 || fail_y !== 16'sd11 || pass_count !== 5'd0) begin
            n_fail++;
            $display("FAIL mismatch_status: got idx=%0d fy=%0d pass=%0d, required 0 11 0", fail_index, fail_y, pass_count);
        end
        n_tests++;
        if (n_en != 1) begin
            n_fail++;
            $display("FAIL mismatch_stop: got %0d pulses, required 1", n_en);
        end
    endtask

    task automatic test_timeout();
        int n_en, min_gap, en_cyc, done_cyc;
        do_reset();
        never_valid = 1'b1;
        load_ok(5, 1, 1, 1, 1'b1);
        pulse_start();
        run_to_done(200, n_en, min_gap, en_cyc, done_cyc);
        n_tests++;
        if (done !== 1'b1 || error !== 1'b1 || timeout !== 1'b1 || fail_index !== 4'd0 || fail_y !== 16'sd0) begin
            n_fail++;
            $display("FAIL timeout_status: got done=%b error=%b timeout=%b idx=%0d fy=%0d, required 1 1 1 0 0",
                     done, error, timeout, fail_index, fail_y);
        end
        // enable is seen in ISSUE; WAIT_VALID starts at the next edge, done TIMEOUT edges later
        n_tests++;
        if (done_cyc - en_cyc != int'(TIMEOUT) + 1) begin
            n_fail++;
            $display("FAIL timeout_latency: got done %0d cycles after enable, required %0d",
                     done_cyc - en_cyc, TIMEOUT + 1);
        end
        never_valid = 1'b0;
    endtask

    task automatic test_empty_start();
        bit saw_en;
        do_reset();
        pulse_start();
        n_tests++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_status: got done=%b error=%b busy=%b, required 1 0 0", done, error, busy);
        end
        saw_en = enable;
        repeat (4) begin
            @(negedge clock);
            if (enable === 1'b1) saw_en = 1'b1;
        end
        n_tests++;
        if (saw_en !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_enable: got a pulse, required none");
        end
    endtask

    task automatic test_full();
        int n_en, min_gap, en_cyc, done_cyc;
        int xv, av, bv, cv;
        do_reset();
        for (int i = 0; i <= int'(DEPTH); i++) begin
            xv = int'($urandom_range(14)) - 7;
            av = int'($urandom_range(20)) - 10;
            bv = int'($urandom_range(40)) - 20;
            cv = int'($urandom_range(200)) - 100;
            load_ok(xv, av, bv, cv, (i < int'(DEPTH)));
            if (i == int'(DEPTH) - 2) begin
                n_tests++;
                if (full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_early: got full=%b after %0d writes, required 0", full, i + 1);
                end
            end
            if (i >= int'(DEPTH) - 1) begin
                n_tests++;
                if (full !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_flag: got full=%b after %0d writes, required 1", full, i + 1);
                end
            end
        end
        pulse_start();
        run_to_done(2000, n_en, min_gap, en_cyc, done_cyc);
        n_tests++;
        if (n_en != int'(DEPTH) || pass_count !== 5'(DEPTH) || error !== 1'b0) begin
            n_fail++;
            $display("FAIL full_run: got pulses=%0d pass=%0d error=%b, required %0d %0d 0",
                     n_en, pass_count, error, DEPTH, DEPTH);
        end
    endtask

    task automatic test_start_with_load();
        int n_en, min_gap, en_cyc, done_cyc;
        do_reset();
        load_ok(1, 2, 3, 4, 1'b1);
        load_ok(-2, 3, 4, -5, 1'b1);
        @(negedge clock);
        load_en   = 1'b1;
        start     = 1'b1;
        load_data = {8'(3), 16'(1), 16'(1), 16'(1), 16'(poly(3, 1, 1, 1))};
        @(negedge clock);
        load_en = 1'b0;
        start   = 1'b0;
        run_to_done(500, n_en, min_gap, en_cyc, done_cyc);
        n_tests++;
        if (n_en != 2 || pass_count !== 5'd2) begin
            n_fail++;
            $display("FAIL start_load_drop: got pulses=%0d pass=%0d, required 2 2", n_en, pass_count);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_en, min_gap, en_cyc, done_cyc, cyc;
        do_reset();
        load_ok(4, 1, -1, 2, 1'b0);
        load_ok(-1, 7, 2, 9, 1'b0);
        pulse_start();
        n_en = 0;
        cyc  = 0;
        while (n_en < 2 && cyc < 300) begin
            @(negedge clock);
            cyc++;
            if (enable === 1'b1) n_en++;
        end
        n_tests++;
        if (n_en != 2) begin
            n_fail++;
            $display("FAIL midrun_reach: got %0d pulses in %0d cycles, required 2", n_en, cyc);
        end
        @(negedge clock);
        n_tests++;
        if (busy !== 1'b1 || pass_count !== 5'd1) begin
            n_fail++;
            $display("FAIL midrun_before: got busy=%b pass=%0d, required 1 1", busy, pass_count);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({enable, busy, done, error, timeout, full} !== 6'b0 || pass_count !== 5'd0 ||
            fail_index !== 4'd0 || fail_y !== 16'sd0 || {x, a, b, c} !== 56'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got flags=%b pass=%0d idx=%0d fy=%0d ops=%h, required all 0",
                     {enable, busy, done, error, timeout, full}, pass_count, fail_index, fail_y, {x, a, b, c});
        end
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        load_ok(3, -2, 5, 1, 1'b1);
        load_ok(6, 1, 0, -30, 1'b1);
        pulse_start();
        run_to_done(500, n_en, min_gap, en_cyc, done_cyc);
        n_tests++;
        if (n_en != 2 || pass_count !== 5'd2 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_rerun: got pulses=%0d pass=%0d error=%b, required 2 2 0", n_en, pass_count, error);
        end
    endtask

    initial begin
        reset     = 1'b1;
        load_en   = 1'b0;
        load_data = '0;
        start     = 1'b0;
        test_reset();
        test_pass();
        test_mismatch();
        test_timeout();
        test_empty_start();
        test_full();
        test_start_with_load();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
